reg_file_sb: RTL and testbench



---
 rtl/reg_file_sb.sv | 145 ++++++++++++++
 tb/tb_reg_file_sb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read / 1-write architectural register file with a
// per-register pending scoreboard and a handshaked dump engine.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rs1_addr/rs1_data/rs1_busy read port 1 (combinational data + pending)
//   rs2_addr/rs2_data/rs2_busy read port 2 (combinational data + pending)
//   wr_en/wr_addr/wr_data      writeback port (clears pending)
//   alloc_en/alloc_addr        decode allocation (sets pending)
//   dump_start                 start streaming all registers (IDLE only)
//   dump_valid/dump_ready      dump beat handshake
//   dump_addr/dump_data        current dump beat
//   dump_done                  one-cycle pulse after the last beat
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  alloc_en,
    input  logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic                  dump_start,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_done
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} dump_state_e;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem;
    logic [NUM_REGS-1:0]                 pending;
    logic [NUM_REGS-1:0]                 wr_hit;
    logic [NUM_REGS-1:0]                 al_hit;
    dump_state_e                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]               ptr_q, ptr_d;

    // One-hot decode of write and alloc targets; the hardwired zero
    // register is masked here so it is never written nor marked pending.
    always_comb begin
        wr_hit = '0;
        al_hit = '0;
        if (wr_en)    wr_hit[wr_addr]    = 1'b1;
        if (alloc_en) al_hit[alloc_addr] = 1'b1;
        if (ZERO_REG) begin
            wr_hit[0] = 1'b0;
            al_hit[0] = 1'b0;
        end
    end

    // Alloc takes priority over writeback so a same-cycle reallocation
    // leaves the register pending for the new producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem     <= '0;
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) mem[i] <= wr_data;
                if (al_hit[i])      pending[i] <= 1'b1;
                else if (wr_hit[i]) pending[i] <= 1'b0;
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] a);
        if (ZERO_REG && a == '0)                  return '0;
        else if (BYPASS && wr_en && wr_addr == a) return wr_data;
        else                                      return mem[a];
    endfunction

    // A write landing this cycle resolves the hazard, so busy is masked.
    function automatic logic busy(input logic [ADDR_WIDTH-1:0] a);
        if (BYPASS && wr_en && wr_addr == a) return 1'b0;
        else                                 return pending[a];
    endfunction

    always_comb rs1_data = rd(rs1_addr);
    always_comb rs2_data = rd(rs2_addr);
    always_comb rs1_busy = busy(rs1_addr);
    always_comb rs2_busy = busy(rs2_addr);

    // Dump engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end
            end
            RUN: begin
                dump_valid = 1'b1;
                if (dump_ready) begin
                    // ptr stops at the last index instead of wrapping
                    if (ptr_q == '1) state_d = DONE;
                    else             ptr_d   = ptr_q + 1'b1;
                end
            end
            DONE: begin
                dump_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat payload is forced to zero outside RUN so idle outputs stay quiet.
    always_comb begin
        dump_addr = '0;
        dump_data = '0;
        if (dump_valid) begin
            dump_addr = ptr_q;
            dump_data = rd(ptr_q);
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs1_addr, rs2_addr, wr_addr, alloc_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en, alloc_en, dump_start, dump_ready;

    logic [DW-1:0] rs1_data, rs2_data, dump_data;
    logic          rs1_busy, rs2_busy, dump_valid, dump_done;
    logic [AW-1:0] dump_addr;

    // Second instance without bypass, sharing all inputs
    logic [DW-1:0] nb_rs1_data, nb_rs2_data, nb_dump_data;
    logic          nb_rs1_busy, nb_rs2_busy, nb_dump_valid, nb_dump_done;
    logic [AW-1:0] nb_dump_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
    );

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
        .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .dump_start(dump_start), .dump_valid(nb_dump_valid), .dump_ready(dump_ready),
        .dump_addr(nb_dump_addr), .dump_data(nb_dump_data), .dump_done(nb_dump_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs a dump with the given ready pattern for a fixed number of cycles
    // and checks every beat against addr k / data k*mult.
    task automatic run_dump(input int cycles, input bit toggle, input int mult);
        int k = 0;
        int dones = 0;
        for (int c = 0; c < cycles; c++) begin
            dump_ready = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            if (c == 0) chk("first_valid", dump_valid, 1'b1);
            if (dump_valid) begin
                chk("beat_in_range", k < 32, 1'b1);
                chk("dump_addr", dump_addr, k);
                chk("dump_data", dump_data, k * mult);
                if (dump_ready) k++;
            end
            if (dump_done) dones++;
            tick();
        end
        dump_ready = 1'b0;
        chk("beat_count", k, 32);
        chk("done_pulses", dones, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        rs1_addr = '0; rs2_addr = '0; wr_addr = '0; alloc_addr = '0;
        wr_data = '0; wr_en = 1'b0; alloc_en = 1'b0;
        dump_start = 1'b0; dump_ready = 1'b0;
        #12;
        chk("rst_dump_valid", dump_valid, 1'b0);
        chk("rst_dump_done", dump_done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Reset contents on every index, both ports
        for (int i = 0; i < 32; i++) begin
            rs1_addr = AW'(i);
            rs2_addr = AW'(31 - i);
            #1;
            chk("rst_rs1_data", rs1_data, 0);
            chk("rst_rs2_data", rs2_data, 0);
            chk("rst_rs1_busy", rs1_busy, 0);
            chk("rst_rs2_busy", rs2_busy, 0);
            tick();
        end

        // Same-cycle bypass vs. no-bypass
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs1_addr = 5;
        #1;
        chk("byp_same_cycle", rs1_data, 32'hDEADBEEF);
        chk("nobyp_same_cycle", nb_rs1_data, 0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("byp_next_cycle", rs1_data, 32'hDEADBEEF);
        chk("nobyp_next_cycle", nb_rs1_data, 32'hDEADBEEF);

        // Zero register
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234; rs1_addr = 0;
        #1;
        chk("x0_same_cycle", rs1_data, 0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("x0_after_write", rs1_data, 0);
        alloc_en = 1'b1; alloc_addr = 0;
        tick();
        alloc_en = 1'b0;
        #1;
        chk("x0_never_busy", rs1_busy, 0);

        // Scoreboard on x7
        rs2_addr = 7; alloc_en = 1'b1; alloc_addr = 7;
        #1;
        chk("alloc_not_yet", rs2_busy, 0);
        tick();
        alloc_en = 1'b0;
        #1;
        chk("alloc_busy", rs2_busy, 1);
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'h77; alloc_en = 1'b1;
        #1;
        chk("wr_alloc_masked", rs2_busy, 0);
        chk("nb_wr_alloc_busy", nb_rs2_busy, 1);
        tick();
        wr_en = 1'b0; alloc_en = 1'b0;
        #1;
        chk("alloc_wins", rs2_busy, 1);
        wr_en = 1'b1; wr_data = 32'h78;
        #1;
        chk("wr_masked", rs2_busy, 0);
        chk("nb_wr_unmasked", nb_rs2_busy, 1);
        tick();
        wr_en = 1'b0;
        #1;
        chk("wr_clears", rs2_busy, 0);
        chk("nb_wr_clears", nb_rs2_busy, 0);

        // Load x1..x31 with i*3, then dump with ready toggling
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i * 3);
            tick();
        end
        wr_en = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        run_dump(80, 1'b1, 3);
        #1;
        chk("idle_after_dump", dump_valid, 0);

        // Reset in the middle of a dump
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        chk("mid_dump_addr", dump_addr, 10);
        chk("mid_dump_data", dump_data, 30);
        rst_n = 1'b0;
        #1;
        chk("async_valid_low", dump_valid, 0);
        chk("async_done_low", dump_done, 0);
        rs1_addr = 3;
        #1;
        chk("rst_clears_mem", rs1_data, 0);
        rst_n = 1'b1;
        dump_ready = 1'b0;
        tick();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        run_dump(40, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
